// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer slice.
// Opcodes here must track the alu decode.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

  localparam int       DEFAULT_W = 16;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01101;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between a controller
// and the ALU sequencer.
interface alu_seq_if #(
  parameter int W = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [4:0]          req_op;
  logic                req_load;
  logic signed [W-1:0] req_operand;
  logic                rsp_valid;
  logic                rsp_ready;
  logic signed [W-1:0] rsp_result;
  logic [3:0]          rsp_flags;

  modport master (
    output req_valid, req_op, req_load, req_operand, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_load, req_operand, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU; flags are {N, Z, C, V}.
// C is carry-out on add and borrow on subtract.
module alu
  import alu_seq_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [4:0]          alu_op,
  input  logic signed [W-1:0] operandA,
  input  logic signed [W-1:0] operandB,
  output logic signed [W-1:0] resultAccumulator,
  output logic [3:0]          flags
);

  logic [W:0]          sum;
  logic signed [W-1:0] res;
  logic                c;
  logic                v;

  always_comb begin
    sum = '0;
    res = operandA;
    c   = 1'b0;
    v   = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        sum = {1'b0, operandA} + {1'b0, operandB};
        res = sum[W-1:0];
        c   = sum[W];
        v   = (operandA[W-1] == operandB[W-1]) &&
              (res[W-1] != operandA[W-1]);
      end
      OP_SUB: begin
        sum = {1'b0, operandA} - {1'b0, operandB};
        res = sum[W-1:0];
        c   = sum[W];
        v   = (operandA[W-1] != operandB[W-1]) &&
              (res[W-1] != operandA[W-1]);
      end
      OP_AND: res = operandA & operandB;
      OP_OR:  res = operandA | operandB;
      OP_XOR: res = operandA ^ operandB;
      OP_NOT: res = ~operandA;
      default: res = operandA;
    endcase
  end

  assign resultAccumulator = res;
  assign flags = {res[W-1], res == '0, c, v};

endmodule

// File: rtl/alu_sequencer.sv
// Registered accumulator front end for alu: one op per
// request handshake, result returned on the response channel.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output logic [15:0] op_count
);

  seq_state_t          state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;
  logic [4:0]          op_q, op_d;
  logic signed [W-1:0] operand_q, operand_d;
  logic                load_q, load_d;
  logic [15:0]         op_count_q, op_count_d;

  logic signed [W-1:0] alu_res;
  logic [3:0]          alu_flags;

  alu #(.W(W)) u_alu (
    .alu_op            (op_q),
    .operandA          (acc_q),
    .operandB          (operand_q),
    .resultAccumulator (alu_res),
    .flags             (alu_flags)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flags_d    = flags_q;
    op_d       = op_q;
    operand_d  = operand_q;
    load_d     = load_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d      = bus.req_op;
          operand_d = bus.req_operand;
          load_d    = bus.req_load;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // A load leaves the flags from the last real ALU op.
        if (load_q) begin
          acc_d = operand_q;
        end else begin
          acc_d   = alu_res;
          flags_d = alu_flags;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      flags_q    <= '0;
      op_q       <= '0;
      operand_q  <= '0;
      load_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      load_q     <= load_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = acc_q;
  assign bus.rsp_flags  = flags_q;
  assign op_count       = op_count_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered front end for the existing combinational `alu`. It accepts one operation per valid/ready request, drives the ALU from an internal accumulator (operand A) and the request operand (operand B), and captures the result and flags into registers. It returns them on a valid/ready response channel. The block is the stimulus-side counterpart the datapath needs once the ALU is driven by a controller instead of a bench.

## Interface
Parameters:
- `W`, 16: datapath width; must match the instantiated `alu`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  5  ALU opcode, passed unmodified to `alu.alu_op`.
- `req_load`  in  1  1 = load `req_operand` into the accumulator; `req_op` is ignored.
- `req_operand`  in  W  signed operand B, or the load value.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  W  signed accumulator value after the operation.
- `rsp_flags`  out  4  flag register after the operation.
- `op_count`  out  16  number of completed responses; wraps modulo 2^16.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, capture `req_op`, `req_load` and `req_operand` into holding registers, then go to EXEC.
- EXEC:
  - `req_ready`=0.
  - `alu` sees `operandA`=acc, `operandB`=held operand, `alu_op`=held op.
  - At the end of the cycle:
    - If `req_load`: acc←operand; flags are unchanged.
    - Otherwise: acc←`resultAccumulator`, flags←`flags`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_result`=acc; `rsp_flags`=flag register.
  - Both outputs are stable while `rsp_valid`=1 and `rsp_ready`=0.
  - When `rsp_ready`=1: `op_count`++ (16-bit wrap, 0xFFFF→0x0000), then go to IDLE.
- Arithmetic is entirely the ALU's. The sequencer does no width extension; acc is W bits signed.
- `req_*` inputs are ignored outside IDLE. The held copies are the only source in EXEC, so upstream may change `req_*` after the handshake.
- Reset values: state=IDLE, acc=0, flags=0, held op/operand/load=0, `op_count`=0.
- Reset output levels: `rsp_valid`=0, `req_ready`=1, `rsp_result`=0, `rsp_flags`=0.
- Reset mid-operation (EXEC or RESP) abandons the operation. No response is issued and `op_count` is not incremented.
- In RESP with `rsp_ready` already high on the entry cycle, the handshake completes in that cycle.

## Timing
- Request accepted at edge N (IDLE, `req_valid`=1).
- EXEC occupies cycle N+1; acc and flags update at edge N+2.
- `rsp_valid`=1 from after edge N+2 until the edge where `rsp_ready`=1.
- Minimum period is 3 cycles per operation; `req_ready` returns 1 the cycle after the response handshake.
- `req_ready` and `rsp_valid` are decoded from state registers only. There is no combinational path from `req_valid` or `rsp_ready`.
- `rsp_result` and `rsp_flags` are direct register outputs.

## Structure
- Package `alu_seq_pkg`:
  - state enum `seq_state_t` {IDLE, EXEC, RESP}.
  - localparam `OP_NOT`=5'b01101.
  - localparam `DEFAULT_W`=16.
- One sub-module: the existing `alu #(W)`, instantiated once. Port map: `alu_op`, `operandA`, `operandB`, `resultAccumulator`, `flags`.
- Everything else is a single sequential process plus output decode.

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-cycle → `rsp_valid`=0, `req_ready`=1, `rsp_result`=0, `op_count`=0 immediately.
- Load then NOT:
  - load -32, handshake response.
  - issue `OP_NOT` → `rsp_valid` 2 cycles after accept, `rsp_result`=31.
  - `op_count`=2.
- NOT sweep: load then NOT for -13→12, 0→-1, 347→-348. The flags after each load equal the flags from the previous ALU op.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP →
  - `rsp_result` and `rsp_flags` stable.
  - `req_ready`=0 throughout.
  - toggling `req_*` has no effect.
- Reset during EXEC: accept NOT on acc=-32, drop `rst_n` in EXEC → no response, acc=0, state IDLE after release.
- Counter wrap: preload `op_count` via 65535 completed loads, then one more → `op_count`=0.
